// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmitter, with done-timeout
// supervision and idle-only baud divisor updates.
module uart_tx_arbiter #(
   parameter int CLK_HZ      = 50000000,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int DIV_W       = 16
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             uart_en,
   input  logic             tx_en,
   input  logic [1:0]       baud_sel,
   input  logic             req0_valid,
   input  logic [7:0]       req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_data,
   output logic             req1_ready,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic [DIV_W-1:0] baud_div,
   output logic             baud_update,
   output logic [1:0]       grant,
   output logic             err_timeout
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCEPT = 2'd1;
   localparam logic [1:0] S_START  = 2'd2;
   localparam logic [1:0] S_WAIT   = 2'd3;

   localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   function automatic logic [DIV_W-1:0] div_of(input logic [1:0] sel);
      case (sel)
         2'b00:   div_of = DIV_W'(CLK_HZ / 4800);
         2'b01:   div_of = DIV_W'(CLK_HZ / 9600);
         2'b10:   div_of = DIV_W'(CLK_HZ / 57600);
         default: div_of = DIV_W'(CLK_HZ / 115200);
      endcase
   endfunction

   logic [1:0]       state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             rr_q, rr_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [DIV_W-1:0] baud_div_q, baud_div_d;
   logic             baud_upd_q, baud_upd_d;
   logic [DIV_W-1:0] sel_div;
   logic             pick1;

   // Transmitter busy is informational; sequencing relies on the done pulse.
   logic unused_busy;
   assign unused_busy = tx_busy;

   assign sel_div = div_of(baud_sel);
   // rr_q=1 means req1 wins a tie.
   assign pick1   = req1_valid & (~req0_valid | rr_q);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      tx_data_d  = tx_data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      baud_div_d = baud_div_q;
      baud_upd_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (uart_en && tx_en && (req0_valid || req1_valid)) begin
               state_d = S_ACCEPT;
               grant_d = pick1 ? 2'b10 : 2'b01;
            end
            if (sel_div != baud_div_q) begin
               baud_div_d = sel_div;
               baud_upd_d = 1'b1;
            end
         end
         S_ACCEPT: begin
            tx_data_d = grant_q[1] ? req1_data : req0_data;
            rr_d      = grant_q[0];
            state_d   = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A done arriving on the timeout cycle completes the byte normally.
            if (tx_done) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
            end else if (cnt_d >= TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
         end
      endcase

      // Soft reset of the sequencer; the pointer and the divisor survive it.
      if (!uart_en) begin
         state_d = S_IDLE;
         grant_d = 2'b00;
         err_d   = 1'b0;
         rr_d    = rr_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         grant_q    <= 2'b00;
         rr_q       <= 1'b0;
         tx_data_q  <= 8'h00;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         baud_div_q <= div_of(2'b01);
         baud_upd_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         tx_data_q  <= tx_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         baud_div_q <= baud_div_d;
         baud_upd_q <= baud_upd_d;
      end
   end

   assign req0_ready  = (state_q == S_ACCEPT) & grant_q[0];
   assign req1_ready  = (state_q == S_ACCEPT) & grant_q[1];
   assign tx_start    = (state_q == S_START);
   assign tx_data     = tx_data_q;
   assign grant       = grant_q;
   assign err_timeout = err_q;
   assign baud_div    = baud_div_q;
   assign baud_update = baud_upd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the arbiter (who gets the byte, when it starts, what gets sent).
module tb_uart_tx_arbiter;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset_n, uart_en, tx_en;
   logic [1:0]  baud_sel;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0]  req0_data, req1_data, tx_data;
   logic        tx_start, tx_busy, tx_done;
   logic [15:0] baud_div;
   logic        baud_update, err_timeout;
   logic [1:0]  grant;

   int total, bad, hits;
   int busy, w, fav, free_from, rdy_cyc, st_cyc, done_cnt;
   logic [7:0] byte_q;
   bit pop0, pop1;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.CLK_HZ(50000000), .TIMEOUT_CYC(TO), .DIV_W(16)) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .uart_en(uart_en), .tx_en(tx_en),
      .baud_sel(baud_sel),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .baud_div(baud_div), .baud_update(baud_update), .grant(grant),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input int obs, input int want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int div_of(input int sel);
      case (sel)
         0:       return 50000000 / 4800;
         1:       return 50000000 / 9600;
         2:       return 50000000 / 57600;
         default: return 50000000 / 115200;
      endcase
   endfunction

   task automatic do_reset(input logic [1:0] sel);
      reset_n = 1'b0; uart_en = 1'b0; tx_en = 1'b0; baud_sel = sel;
      req0_valid = 1'b0; req1_valid = 1'b0; tx_done = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_start(input string tag);
      int k;
      k = 0;
      while (tx_start !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk(tag, int'(tx_start), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; uart_en = 1'b0; tx_en = 1'b0; baud_sel = 2'b01;
      req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b0; req1_data = 8'h00;
      tx_busy = 1'b0; tx_done = 1'b0;
      tick(); tick();
      chk("rst_div", int'(baud_div), div_of(1));
      chk("rst_upd", int'(baud_update), 0);
      chk("rst_grant", int'(grant), 0);
      chk("rst_start", int'(tx_start), 0);
      chk("rst_rdy", int'({req1_ready, req0_ready}), 0);
      chk("rst_err", int'(err_timeout), 0);
      chk("rst_data", int'(tx_data), 0);

      // baud change while idle
      reset_n = 1'b1; baud_sel = 2'b11;
      tick();
      chk("bd_div", int'(baud_div), div_of(3));
      chk("bd_upd", int'(baud_update), 1);
      tick();
      chk("bd_upd_off", int'(baud_update), 0);
      chk("bd_div_hold", int'(baud_div), div_of(3));

      // single byte from req0
      uart_en = 1'b1; tx_en = 1'b1; req0_valid = 1'b1; req0_data = 8'h41;
      tick();
      chk("s_rdy", int'(req0_ready), 1);
      chk("s_grant", int'(grant), 1);
      chk("s_start_early", int'(tx_start), 0);
      tick();
      chk("s_start", int'(tx_start), 1);
      chk("s_data", int'(tx_data), 'h41);
      chk("s_rdy_off", int'(req0_ready), 0);
      req0_valid = 1'b0; req0_data = 8'h00;
      repeat (19) tick();
      chk("s_hold", int'(tx_data), 'h41);
      chk("s_wait_grant", int'(grant), 1);
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      chk("s_done_grant", int'(grant), 0);

      // round robin with both requesters always valid
      do_reset(2'b01);
      uart_en = 1'b1; tx_en = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         wait_start("rr_start");
         chk("rr_data", int'(tx_data), (i % 2) ? 'h22 : 'h11);
         chk("rr_grant", int'(grant), (i % 2) ? 2 : 1);
         repeat (3) tick();
         tx_done = 1'b1; tick(); tx_done = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // baud change requested mid-transfer is deferred to idle
      req0_valid = 1'b1; req0_data = 8'h5A;
      wait_start("bw_start");
      req0_valid = 1'b0;
      tick();
      baud_sel = 2'b10;
      repeat (5) begin
         tick();
         chk("bw_defer", int'(baud_div), div_of(1));
      end
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      chk("bw_idle_div", int'(baud_div), div_of(1));
      chk("bw_idle_grant", int'(grant), 0);
      tick();
      chk("bw_div", int'(baud_div), div_of(2));
      chk("bw_upd", int'(baud_update), 1);
      tick();
      chk("bw_upd_off", int'(baud_update), 0);

      // done never comes
      req1_valid = 1'b1; req1_data = 8'h7E;
      wait_start("to_start");
      req1_valid = 1'b0;
      repeat (TO - 1) tick();
      chk("to_pre_err", int'(err_timeout), 0);
      chk("to_pre_grant", int'(grant), 2);
      tick();
      chk("to_err", int'(err_timeout), 1);
      chk("to_grant", int'(grant), 0);
      tick();
      chk("to_sticky", int'(err_timeout), 1);
      uart_en = 1'b0;
      tick();
      chk("to_clr", int'(err_timeout), 0);
      uart_en = 1'b1;

      // uart_en drop in the middle of a transfer, then tx_en gating
      req0_valid = 1'b1; req0_data = 8'h33;
      wait_start("ue_start");
      req0_valid = 1'b0;
      tick();
      uart_en = 1'b0;
      tick();
      chk("ue_grant", int'(grant), 0);
      req1_valid = 1'b1; req1_data = 8'h44;
      hits = 0;
      repeat (10) begin
         tick();
         hits += int'(tx_start) + int'(req0_ready) + int'(req1_ready);
      end
      chk("ue_quiet", hits, 0);
      uart_en = 1'b1; tx_en = 1'b0;
      hits = 0;
      repeat (10) begin
         tick();
         hits += int'(req0_ready) + int'(req1_ready) + int'(tx_start);
      end
      chk("te_block", hits, 0);
      req1_valid = 1'b0; tx_en = 1'b1;
      tick();

      // randomized traffic against the transaction model
      do_reset(2'b01);
      uart_en = 1'b1; tx_en = 1'b1;
      busy = 0; w = 0; fav = 0; free_from = 0; rdy_cyc = -10; st_cyc = -10;
      done_cnt = 0; byte_q = 8'h00; pop0 = 1'b0; pop1 = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         // an ongoing byte ends on the first done after its start; the link
         // is offered again one cycle later
         if (busy != 0) begin
            if (tx_done && n > st_cyc) begin
               busy = 0;
               free_from = n + 1;
            end
         end else if (n >= free_from && tx_en && (req0_valid || req1_valid)) begin
            w = (req0_valid && req1_valid) ? fav : (req1_valid ? 1 : 0);
            fav = 1 - w;
            busy = 1;
            rdy_cyc = n;
            st_cyc = n + 1;
            byte_q = (w != 0) ? req1_data : req0_data;
         end
         chk("m_rdy0", int'(req0_ready), int'(busy != 0 && n == rdy_cyc && w == 0));
         chk("m_rdy1", int'(req1_ready), int'(busy != 0 && n == rdy_cyc && w == 1));
         chk("m_start", int'(tx_start), int'(n == st_cyc));
         chk("m_grant", int'(grant), (busy != 0) ? ((w != 0) ? 2 : 1) : 0);
         if (busy != 0 && n >= st_cyc) chk("m_data", int'(tx_data), int'(byte_q));
         chk("m_err", int'(err_timeout), 0);

         if (tx_start) done_cnt = $urandom_range(2, 25);
         if (done_cnt > 0) begin
            done_cnt--;
            tx_done = (done_cnt == 0);
         end else begin
            tx_done = ($urandom_range(0, 19) == 0);
         end
         if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;

         if (pop0) begin
            pop0 = 1'b0;
            req0_valid = 1'($urandom_range(0, 1));
            req0_data = 8'($urandom);
         end else if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_valid = 1'b1;
            req0_data = 8'($urandom);
         end
         if (req0_ready) pop0 = 1'b1;
         if (pop1) begin
            pop1 = 1'b0;
            req1_valid = 1'($urandom_range(0, 1));
            req1_data = 8'($urandom);
         end else if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_valid = 1'b1;
            req1_data = 8'($urandom);
         end
         if (req1_ready) pop1 = 1'b1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; tx_done = 1'b0; tx_en = 1'b1;
      repeat (30) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Sits between byte sources and the single UART transmitter on the DE-board top.
- Arbitrates two byte requesters round-robin and sequences each accepted byte into the transmitter with a start pulse.
- Waits for the transmitter's done pulse before granting the next byte.
- Owns baud configuration: maps the 2-bit switch selection to a 50 MHz prescaler divisor and applies changes only while the link is idle.

Parameters:
- CLK_HZ, 50000000, system clock frequency; divisor = CLK_HZ / baud, integer truncation.
- TIMEOUT_CYC, 2000000, max cycles in WAIT_DONE before abort. Must be >= 10 bit-times at the slowest baud.
- DIV_W, 16, width of baud_div.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- uart_en  in  1  global UART enable; low acts as a soft reset of the sequencer (not of baud_div).
- tx_en  in  1  transmit enable; low blocks new grants.
- baud_sel  in  2  baud selection.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmit, held stable from start until done.
- tx_busy  in  1  transmitter busy (status only, not used for sequencing).
- tx_done  in  1  one-cycle pulse at end of stop bit.
- baud_div  out  DIV_W  prescaler divisor.
- baud_update  out  1  one-cycle pulse when baud_div changes.
- grant  out  2  one-hot owner of the current transfer; 00 when idle.
- err_timeout  out  1  sticky; set on done timeout.

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0 except baud_div = divisor for baud_sel 01; round-robin pointer = 0 (req0 has priority next); timeout counter = 0.
- Baud map: 00→4800 (10416), 01→9600 (5208), 10→57600 (868), 11→115200 (434) at CLK_HZ = 50 MHz.
- Baud change: in IDLE only, if baud_sel maps to a value different from baud_div, load it and pulse baud_update for 1 cycle. In other states the change is deferred until IDLE.
- States: IDLE, ACCEPT, START, WAIT_DONE.
- IDLE → ACCEPT when uart_en & tx_en & (req0_valid | req1_valid):
  - both valid: pick the requester the pointer favours;
  - one valid: pick it.
  - Set grant one-hot.
- ACCEPT, 1 cycle:
  - selected reqN_ready=1; tx_data captured from reqN_data at this edge.
  - pointer flips to favour the other requester.
  - Requesters must hold valid/data stable until ready; no retraction.
- START, 1 cycle: tx_start=1; timeout counter cleared.
- WAIT_DONE:
  - tx_done → IDLE, grant=00.
  - counter reaching TIMEOUT_CYC-1 → err_timeout=1, go to IDLE.
  - tx_done in the same cycle as timeout: done wins, no error.
- Latency: valid seen in IDLE at edge k → ready high in cycle k+1, tx_start high in cycle k+2.
- Minimum IDLE dwell is 1 cycle between transfers, so each transfer takes done + 3 cycles.
- uart_en=0 in any state:
  - next edge → IDLE; ready/start/grant = 0;
  - an accepted byte not yet done is dropped;
  - err_timeout cleared; pointer kept.
- tx_en=0 mid-transfer: the current byte completes; no new grant.
- tx_done outside WAIT_DONE is ignored.
- err_timeout is cleared only by reset or uart_en=0.

Test Plan:
- Reset with baud_sel=01 → baud_div=5208, grant=00, all pulses 0; release, set baud_sel=11 → 1-cycle baud_update, baud_div=434.
- uart_en=tx_en=1, req0_valid with 0x41 → req0_ready 1 cycle later, tx_start the next cycle, tx_data=0x41; tx_done after 20 cycles → grant=00.
- Both valid (0x11 / 0x22) continuously, done returned each time → accepted order 0x11, 0x22, 0x11, 0x22; grant alternates 01/10.
- baud_sel changed 01→10 during WAIT_DONE → baud_div unchanged until the cycle after done, then 868 with baud_update pulse.
- No tx_done, TIMEOUT_CYC=100 → err_timeout=1 exactly 100 cycles after tx_start, state IDLE; uart_en low then high → err_timeout=0.
- uart_en dropped in WAIT_DONE → next cycle grant=00, no further tx_start; tx_en=0 with req valid → ready never asserts.
